// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle for the register slave: AW/W/B/AR/R channels.
interface axi4lite_reg_slave_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register slave: CTRL/SCRATCH (R/W), WCOUNT (RO write counter),
// ID (RO constant). AW and W are captured independently; one write and one
// read in flight at a time. CTRL is exported live on ctrl_out.
module axi4lite_reg_slave #(
  parameter int          ADDR_W   = 5,
  parameter int          CNT_W    = 8,
  parameter logic [31:0] ID_VALUE = 32'hA41E0001
) (
  input  logic                sysclk,
  input  logic                rst,
  axi4lite_reg_slave_if.slave s_axi,
  output logic [31:0]         ctrl_out
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SEL_CTRL    = 2'd0;
  localparam logic [1:0] SEL_SCRATCH = 2'd1;
  localparam logic [1:0] SEL_WCOUNT  = 2'd2;
  localparam logic [1:0] SEL_ID      = 2'd3;

  // write capture state
  logic              r_aw_held;
  logic [ADDR_W-1:0] r_awaddr;
  logic              r_w_held;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  // write response
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  // read response
  logic              r_rvalid;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  // register file
  logic [31:0]       r_ctrl;
  logic [31:0]       r_scratch;
  logic [CNT_W-1:0]  r_wcount;

  logic              w_awready, w_wready, w_arready;
  logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_wdata;
  logic [3:0]        w_wstrb;
  logic              w_wmapped;
  logic [1:0]        w_wsel;
  logic              w_wr_ok;
  logic [1:0]        w_bresp;
  logic [31:0]       w_ctrl_merge, w_scratch_merge;
  logic              w_rmapped;
  logic [1:0]        w_rsel;
  logic [31:0]       w_rdata;
  logic [1:0]        w_rresp;
  logic              w_unused;

  // Readies are pure functions of internal state (no input -> ready path).
  assign w_awready = !r_aw_held && !r_bvalid;
  assign w_wready  = !r_w_held  && !r_bvalid;
  assign w_arready = !r_rvalid;

  assign s_axi.s_axi_awready = w_awready;
  assign s_axi.s_axi_wready  = w_wready;
  assign s_axi.s_axi_arready = w_arready;
  assign s_axi.s_axi_bvalid  = r_bvalid;
  assign s_axi.s_axi_bresp   = r_bresp;
  assign s_axi.s_axi_rvalid  = r_rvalid;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign s_axi.s_axi_rresp   = r_rresp;
  assign ctrl_out            = r_ctrl;

  assign w_aw_hs = s_axi.s_axi_awvalid && w_awready;
  assign w_w_hs  = s_axi.s_axi_wvalid  && w_wready;
  assign w_ar_hs = s_axi.s_axi_arvalid && w_arready;

  // Commit once both halves are present, either held or arriving this edge.
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  // Bypass the holding registers for whichever half arrives on the commit edge.
  assign w_waddr = w_aw_hs ? s_axi.s_axi_awaddr : r_awaddr;
  assign w_wdata = w_w_hs  ? s_axi.s_axi_wdata  : r_wdata;
  assign w_wstrb = w_w_hs  ? s_axi.s_axi_wstrb  : r_wstrb;

  // Only 0x00-0x0F is populated; byte offset bits are ignored.
  assign w_wmapped = (w_waddr[ADDR_W-1:4] == '0);
  assign w_wsel    = w_waddr[3:2];
  assign w_wr_ok   = w_wmapped && (w_wsel == SEL_CTRL || w_wsel == SEL_SCRATCH);

  // Write response code from the decoded target.
  always_comb begin
    w_bresp = RESP_OKAY;
    if (!w_wmapped)   w_bresp = RESP_DECERR;
    else if (!w_wr_ok) w_bresp = RESP_SLVERR;
  end

  // Byte-lane merge of the write data into the current register values.
  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign w_ctrl_merge[b*8 +: 8]    = w_wstrb[b] ? w_wdata[b*8 +: 8] : r_ctrl[b*8 +: 8];
    assign w_scratch_merge[b*8 +: 8] = w_wstrb[b] ? w_wdata[b*8 +: 8] : r_scratch[b*8 +: 8];
  end

  // AW/W holding registers; commit releases both.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_held <= 1'b1;
        if (w_w_hs)  r_w_held  <= 1'b1;
      end
      if (w_aw_hs) r_awaddr <= s_axi.s_axi_awaddr;
      if (w_w_hs) begin
        r_wdata <= s_axi.s_axi_wdata;
        r_wstrb <= s_axi.s_axi_wstrb;
      end
    end
  end

  // Write response channel: raised on commit, held until accepted.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_bresp;
    end else if (r_bvalid && s_axi.s_axi_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Register file update and count of successful writes.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_scratch <= '0;
      r_wcount  <= '0;
    end else if (w_commit && w_wr_ok) begin
      if (w_wsel == SEL_CTRL)    r_ctrl    <= w_ctrl_merge;
      if (w_wsel == SEL_SCRATCH) r_scratch <= w_scratch_merge;
      r_wcount <= r_wcount + 1'b1;
    end
  end

  assign w_rmapped = (s_axi.s_axi_araddr[ADDR_W-1:4] == '0);
  assign w_rsel    = s_axi.s_axi_araddr[3:2];

  // Read mux over the pre-write register contents.
  always_comb begin
    w_rdata = '0;
    w_rresp = RESP_OKAY;
    if (!w_rmapped) begin
      w_rresp = RESP_DECERR;
    end else begin
      case (w_rsel)
        SEL_CTRL:    w_rdata = r_ctrl;
        SEL_SCRATCH: w_rdata = r_scratch;
        SEL_WCOUNT:  w_rdata = {{(32-CNT_W){1'b0}}, r_wcount};
        SEL_ID:      w_rdata = ID_VALUE;
        default:     w_rdata = '0;
      endcase
    end
  end

  // Read response channel: registered on AR, held until accepted.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdata;
      r_rresp  <= w_rresp;
    end else if (r_rvalid && s_axi.s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // Byte-offset address bits are intentionally ignored.
  assign w_unused = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0], r_awaddr[1:0]};
endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave: handshakes, address map, responses,
// backpressure, counter wrap and asynchronous reset.
module tb_axi4lite_reg_slave;
  logic        sysclk = 1'b0;
  logic        rst    = 1'b1;
  logic [31:0] ctrl_out;
  int          n_chk  = 0;
  int          n_err  = 0;

  axi4lite_reg_slave_if #(.ADDR_W(5)) axi ();

  axi4lite_reg_slave #(.ADDR_W(5), .CNT_W(8), .ID_VALUE(32'hA41E0001)) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .s_axi    (axi.slave),
    .ctrl_out (ctrl_out)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done, hs_aw, hs_w;
    int   n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    axi.s_axi_awaddr  = addr;
    axi.s_axi_wdata   = data;
    axi.s_axi_wstrb   = strb;
    axi.s_axi_awvalid = 1'b1;
    axi.s_axi_wvalid  = 1'b1;
    axi.s_axi_bready  = 1'b1;
    while (!(aw_done && w_done) && n < 16) begin
      hs_aw = axi.s_axi_awvalid && axi.s_axi_awready;
      hs_w  = axi.s_axi_wvalid  && axi.s_axi_wready;
      step();
      n++;
      if (hs_aw) begin axi.s_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin axi.s_axi_wvalid  = 1'b0; w_done  = 1'b1; end
    end
    axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wvalid  = 1'b0;
    chk("wr_bvalid_latency", {31'd0, axi.s_axi_bvalid}, 32'd1);
    resp = axi.s_axi_bresp;
    step();
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic done, hs;
    int   n;
    done = 1'b0; n = 0;
    axi.s_axi_araddr  = addr;
    axi.s_axi_arvalid = 1'b1;
    axi.s_axi_rready  = 1'b1;
    while (!done && n < 16) begin
      hs = axi.s_axi_arvalid && axi.s_axi_arready;
      step();
      n++;
      if (hs) begin axi.s_axi_arvalid = 1'b0; done = 1'b1; end
    end
    axi.s_axi_arvalid = 1'b0;
    chk("rd_rvalid_latency", {31'd0, axi.s_axi_rvalid}, 32'd1);
    data = axi.s_axi_rdata;
    resp = axi.s_axi_rresp;
    step();
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int          bad;

    axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata  = '0; axi.s_axi_wstrb   = '0; axi.s_axi_wvalid = 1'b0;
    axi.s_axi_bready = 1'b0;
    axi.s_axi_araddr = '0; axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    // reset state
    chk("rst_awready", {31'd0, axi.s_axi_awready}, 32'd1);
    chk("rst_wready",  {31'd0, axi.s_axi_wready},  32'd1);
    chk("rst_arready", {31'd0, axi.s_axi_arready}, 32'd1);
    chk("rst_bvalid",  {31'd0, axi.s_axi_bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, axi.s_axi_rvalid},  32'd0);
    chk("rst_bresp",   {30'd0, axi.s_axi_bresp},   32'd0);
    chk("rst_rresp",   {30'd0, axi.s_axi_rresp},   32'd0);
    chk("rst_rdata",   axi.s_axi_rdata,            32'd0);
    chk("rst_ctrl",    ctrl_out,                   32'd0);

    // AW+W together to CTRL -> LED on, WCOUNT = 1
    axi_write(5'h00, 32'h0000_0001, 4'b1111, rsp);
    chk("t1_bresp", {30'd0, rsp}, 32'd0);
    chk("t1_led",   {31'd0, ctrl_out[0]}, 32'd1);
    axi_read(5'h08, rd, rsp);
    chk("t1_wcount", rd, 32'd1);

    // W first, AW three cycles later -> SCRATCH = 0x00AD00EF, WCOUNT = 2
    axi.s_axi_wdata = 32'hDEAD_BEEF; axi.s_axi_wstrb = 4'b0101;
    axi.s_axi_wvalid = 1'b1; axi.s_axi_bready = 1'b1;
    step();
    axi.s_axi_wvalid = 1'b0;
    chk("t2_wready_held", {31'd0, axi.s_axi_wready}, 32'd0);
    chk("t2_no_bvalid0",  {31'd0, axi.s_axi_bvalid}, 32'd0);
    step();
    chk("t2_no_bvalid1",  {31'd0, axi.s_axi_bvalid}, 32'd0);
    step();
    chk("t2_no_bvalid2",  {31'd0, axi.s_axi_bvalid}, 32'd0);
    axi.s_axi_awaddr = 5'h04; axi.s_axi_awvalid = 1'b1;
    step();
    axi.s_axi_awvalid = 1'b0;
    chk("t2_bvalid", {31'd0, axi.s_axi_bvalid}, 32'd1);
    chk("t2_bresp",  {30'd0, axi.s_axi_bresp},  32'd0);
    step();
    axi_read(5'h04, rd, rsp);
    chk("t2_scratch", rd, 32'h00AD_00EF);

    // error responses; WCOUNT stays 2
    axi_write(5'h0C, 32'hFFFF_FFFF, 4'b1111, rsp);
    chk("t3_id_slverr", {30'd0, rsp}, 32'd2);
    axi_write(5'h08, 32'h0000_0055, 4'b1111, rsp);
    chk("t3_wc_slverr", {30'd0, rsp}, 32'd2);
    axi_write(5'h14, 32'h1234_5678, 4'b1111, rsp);
    chk("t3_decerr",    {30'd0, rsp}, 32'd3);
    axi_read(5'h18, rd, rsp);
    chk("t3_rd_decerr_resp", {30'd0, rsp}, 32'd3);
    chk("t3_rd_decerr_data", rd, 32'd0);
    axi_read(5'h0C, rd, rsp);
    chk("t3_id",      rd, 32'hA41E_0001);
    chk("t3_id_resp", {30'd0, rsp}, 32'd0);
    axi_read(5'h08, rd, rsp);
    chk("t3_wcount", rd, 32'd2);

    // strobe 0000 is a no-op that still counts -> CTRL 1, WCOUNT 3
    axi_write(5'h00, 32'hFFFF_FFFF, 4'b0000, rsp);
    chk("t4_nostrb_resp", {30'd0, rsp}, 32'd0);
    chk("t4_nostrb_ctrl", ctrl_out, 32'd1);
    axi_read(5'h08, rd, rsp);
    chk("t4_wcount", rd, 32'd3);

    // read and write commit on the same edge to CTRL -> read sees old value
    axi.s_axi_awaddr = 5'h00; axi.s_axi_wdata = 32'h0000_00A5; axi.s_axi_wstrb = 4'b0001;
    axi.s_axi_araddr = 5'h00;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1; axi.s_axi_arvalid = 1'b1;
    axi.s_axi_bready = 1'b1; axi.s_axi_rready = 1'b1;
    step();
    axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; axi.s_axi_arvalid = 1'b0;
    chk("t5_bvalid", {31'd0, axi.s_axi_bvalid}, 32'd1);
    chk("t5_rvalid", {31'd0, axi.s_axi_rvalid}, 32'd1);
    chk("t5_rd_old", axi.s_axi_rdata, 32'd1);
    chk("t5_ctrl",   ctrl_out, 32'h0000_00A5);
    step();
    chk("t5_bclear", {31'd0, axi.s_axi_bvalid}, 32'd0);
    chk("t5_rclear", {31'd0, axi.s_axi_rvalid}, 32'd0);

    // write-response backpressure (WCOUNT -> 5)
    axi.s_axi_awaddr = 5'h04; axi.s_axi_wdata = 32'h1234_5678; axi.s_axi_wstrb = 4'b1111;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1; axi.s_axi_bready = 1'b0;
    step();
    axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t6_bvalid_hold",  {31'd0, axi.s_axi_bvalid},  32'd1);
      chk("t6_bresp_hold",   {30'd0, axi.s_axi_bresp},   32'd0);
      chk("t6_awready_low",  {31'd0, axi.s_axi_awready}, 32'd0);
      chk("t6_wready_low",   {31'd0, axi.s_axi_wready},  32'd0);
      step();
    end
    axi.s_axi_bready = 1'b1;
    step();
    chk("t6_bvalid_drop", {31'd0, axi.s_axi_bvalid},  32'd0);
    chk("t6_awready_up",  {31'd0, axi.s_axi_awready}, 32'd1);

    // read-data backpressure
    axi.s_axi_araddr = 5'h00; axi.s_axi_arvalid = 1'b1; axi.s_axi_rready = 1'b0;
    step();
    axi.s_axi_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_rvalid_hold", {31'd0, axi.s_axi_rvalid},  32'd1);
      chk("t6_rdata_hold",  axi.s_axi_rdata,            32'h0000_00A5);
      chk("t6_arready_low", {31'd0, axi.s_axi_arready}, 32'd0);
      step();
    end
    axi.s_axi_rready = 1'b1;
    step();
    chk("t6_rvalid_drop", {31'd0, axi.s_axi_rvalid},  32'd0);
    chk("t6_arready_up",  {31'd0, axi.s_axi_arready}, 32'd1);
    axi_read(5'h08, rd, rsp);
    chk("t6_wcount", rd, 32'd5);

    // WCOUNT wrap from a clean reset: 255 writes -> 0xFF, one more -> 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      axi_write(5'h04, i, 4'b1111, rsp);
      if (rsp !== 2'b00) bad++;
    end
    axi_read(5'h08, rd, rsp);
    chk("t7_wcount_max", rd, 32'h0000_00FF);
    axi_write(5'h04, 32'd255, 4'b1111, rsp);
    if (rsp !== 2'b00) bad++;
    chk("t7_bresp_all", bad, 32'd0);
    axi_read(5'h08, rd, rsp);
    chk("t7_wcount_wrap", rd, 32'd0);
    axi_read(5'h04, rd, rsp);
    chk("t7_scratch_last", rd, 32'd255);
    axi_read(5'h00, rd, rsp);
    chk("t7_ctrl_reset", rd, 32'd0);

    // async reset mid-transaction: AW held, W pending, read response waiting
    axi_write(5'h00, 32'h0000_003C, 4'b1111, rsp);
    chk("t8_ctrl_pre", ctrl_out, 32'h0000_003C);
    axi.s_axi_awaddr = 5'h00; axi.s_axi_awvalid = 1'b1;
    axi.s_axi_araddr = 5'h04; axi.s_axi_arvalid = 1'b1; axi.s_axi_rready = 1'b0;
    step();
    axi.s_axi_awvalid = 1'b0; axi.s_axi_arvalid = 1'b0;
    chk("t8_aw_held",  {31'd0, axi.s_axi_awready}, 32'd0);
    chk("t8_rvalid_a", {31'd0, axi.s_axi_rvalid},  32'd1);
    axi.s_axi_wdata = 32'h0000_0077; axi.s_axi_wstrb = 4'b1111; axi.s_axi_wvalid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("t8_async_rvalid",  {31'd0, axi.s_axi_rvalid},  32'd0);
    chk("t8_async_bvalid",  {31'd0, axi.s_axi_bvalid},  32'd0);
    chk("t8_async_ctrl",    ctrl_out,                   32'd0);
    chk("t8_async_awready", {31'd0, axi.s_axi_awready}, 32'd1);
    axi.s_axi_wvalid = 1'b0;
    step();
    rst = 1'b0;
    axi.s_axi_rready = 1'b1; axi.s_axi_bready = 1'b1;
    // lone W must not complete against a discarded AW
    axi.s_axi_wdata = 32'h0000_00FF; axi.s_axi_wvalid = 1'b1;
    step();
    axi.s_axi_wvalid = 1'b0;
    chk("t8_no_stale_aw", {31'd0, axi.s_axi_bvalid}, 32'd0);
    axi.s_axi_awaddr = 5'h00; axi.s_axi_awvalid = 1'b1;
    step();
    axi.s_axi_awvalid = 1'b0;
    chk("t8_fresh_bvalid", {31'd0, axi.s_axi_bvalid}, 32'd1);
    chk("t8_fresh_bresp",  {30'd0, axi.s_axi_bresp},  32'd0);
    chk("t8_fresh_ctrl",   ctrl_out, 32'h0000_00FF);
    step();
    chk("t8_fresh_bdrop",  {31'd0, axi.s_axi_bvalid}, 32'd0);
    axi_read(5'h08, rd, rsp);
    chk("t8_wcount", rd, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
